// File: rtl/cmp_stream_if.sv
// Operand/result handshake bundle for cmp_stream.
// With CMP_STREAM_TOL_EN defined, the bundle also carries a per-pair tolerance.
interface cmp_stream_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             a_gt;
  logic             b_gt;
  logic             eq;
`ifdef CMP_STREAM_TOL_EN
  logic [WIDTH-1:0] tol;

  modport master (
    output in_valid, a, b, signed_mode, tol, out_ready,
    input  in_ready, out_valid, a_gt, b_gt, eq
  );
  modport slave (
    input  in_valid, a, b, signed_mode, tol, out_ready,
    output in_ready, out_valid, a_gt, b_gt, eq
  );
`else
  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, a_gt, b_gt, eq
  );
  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, a_gt, b_gt, eq
  );
`endif
endinterface

// File: rtl/cmp_stream.sv
// Registered signed/unsigned magnitude comparator with valid/ready on both sides
// and saturating result counters. Macro CMP_STREAM_TOL_EN enables tolerance-equality.
//
// state   | meaning
// S_EMPTY | no result held; always ready for a new pair
// S_FULL  | result registers hold an unconsumed result
module cmp_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  cmp_stream_if.slave      bus,
  input  logic             clr_cnt_i,
  output logic [CNT_W-1:0] gt_cnt_o,
  output logic [CNT_W-1:0] lt_cnt_o,
  output logic [CNT_W-1:0] eq_cnt_o
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t           state_q, state_d;
  logic             accept;
  logic             a_gt_q, b_gt_q, eq_q;
  logic [CNT_W-1:0] gt_cnt_q, lt_cnt_q, eq_cnt_q;
  logic [WIDTH-1:0] a_x, b_x;
  logic             gt_c, lt_c, eq_c;
  logic             gt_r, lt_r, eq_r;

  // Flipping the MSB in signed mode maps two's-complement order onto unsigned order.
  always_comb begin
    a_x  = {bus.a[WIDTH-1] ^ bus.signed_mode, bus.a[WIDTH-2:0]};
    b_x  = {bus.b[WIDTH-1] ^ bus.signed_mode, bus.b[WIDTH-2:0]};
    gt_c = (a_x > b_x);
    lt_c = (a_x < b_x);
    eq_c = (a_x == b_x);
  end

`ifdef CMP_STREAM_TOL_EN
  logic [WIDTH:0] a_e, b_e, diff, mag;
  logic           in_tol;

  always_comb begin
    a_e    = {bus.signed_mode & bus.a[WIDTH-1], bus.a};
    b_e    = {bus.signed_mode & bus.b[WIDTH-1], bus.b};
    diff   = a_e - b_e;
    mag    = diff[WIDTH] ? (~diff + 1'b1) : diff;
    in_tol = (mag <= {1'b0, bus.tol});
    eq_r   = in_tol;
    gt_r   = !in_tol && gt_c;
    lt_r   = !in_tol && lt_c;
  end
`else
  always_comb begin
    eq_r = eq_c;
    gt_r = gt_c;
    lt_r = lt_c;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_FULL;
      S_FULL:  if (bus.out_ready && !accept) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == S_EMPTY) || bus.out_ready;
    accept        = bus.in_valid && bus.in_ready;
    bus.out_valid = (state_q == S_FULL);
    bus.a_gt      = a_gt_q;
    bus.b_gt      = b_gt_q;
    bus.eq        = eq_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_gt_q <= 1'b0;
      b_gt_q <= 1'b0;
      eq_q   <= 1'b0;
    end else if (accept) begin
      a_gt_q <= gt_r;
      b_gt_q <= lt_r;
      eq_q   <= eq_r;
    end
  end

  // Clear wins over a same-cycle accept; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_cnt_q <= '0;
      lt_cnt_q <= '0;
      eq_cnt_q <= '0;
    end else if (clr_cnt_i) begin
      gt_cnt_q <= '0;
      lt_cnt_q <= '0;
      eq_cnt_q <= '0;
    end else if (accept) begin
      if (gt_r && gt_cnt_q != '1) gt_cnt_q <= gt_cnt_q + 1'b1;
      if (lt_r && lt_cnt_q != '1) lt_cnt_q <= lt_cnt_q + 1'b1;
      if (eq_r && eq_cnt_q != '1) eq_cnt_q <= eq_cnt_q + 1'b1;
    end
  end

  assign gt_cnt_o = gt_cnt_q;
  assign lt_cnt_o = lt_cnt_q;
  assign eq_cnt_o = eq_cnt_q;

endmodule

// File: tb/tb_cmp_stream.sv
// Directed, table-driven bench for cmp_stream (WIDTH=8, CNT_W=2 so saturation is reachable).
// Tolerance vectors are added when CMP_STREAM_TOL_EN is defined.
module tb_cmp_stream;
  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  localparam logic [1:0] R_EQ = 2'd0;
  localparam logic [1:0] R_GT = 2'd1;
  localparam logic [1:0] R_LT = 2'd2;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sm;
    logic [WIDTH-1:0] tol;
    logic [1:0]       res;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic             clr_cnt;
  logic [CNT_W-1:0] gt_cnt, lt_cnt, eq_cnt;

  cmp_stream_if #(.WIDTH(WIDTH)) bus ();

  cmp_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clr_cnt_i (clr_cnt),
    .gt_cnt_o  (gt_cnt),
    .lt_cnt_o  (lt_cnt),
    .eq_cnt_o  (eq_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int m_gt  = 0;
  int m_lt  = 0;
  int m_eq  = 0;
  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, " gt_cnt"}, 32'(gt_cnt), 32'(m_gt));
    chk({tag, " lt_cnt"}, 32'(lt_cnt), 32'(m_lt));
    chk({tag, " eq_cnt"}, 32'(eq_cnt), 32'(m_eq));
  endtask

  task automatic chk_res(input string tag, input logic [1:0] res);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, " a_gt"}, 32'(bus.a_gt), 32'(res == R_GT));
    chk({tag, " b_gt"}, 32'(bus.b_gt), 32'(res == R_LT));
    chk({tag, " eq"},   32'(bus.eq),   32'(res == R_EQ));
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic count(input logic [1:0] res);
    if (res == R_GT) m_gt = sat(m_gt);
    if (res == R_LT) m_lt = sat(m_lt);
    if (res == R_EQ) m_eq = sat(m_eq);
  endtask

  function automatic vec_t mk(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic sm, input logic [WIDTH-1:0] tol, input logic [1:0] res);
    vec_t v;
    v.a = a; v.b = b; v.sm = sm; v.tol = tol; v.res = res;
    return v;
  endfunction

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic sm, input logic [WIDTH-1:0] tol);
    bus.in_valid    = 1'b1;
    bus.a           = a;
    bus.b           = b;
    bus.signed_mode = sm;
`ifdef CMP_STREAM_TOL_EN
    bus.tol         = tol;
`else
    if (tol != '0) $display("note: tolerance ignored in this build");
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vq.push_back(mk(8'd200, 8'd100, 1'b0, 8'd0, R_GT));
    vq.push_back(mk(8'd5,   8'd5,   1'b0, 8'd0, R_EQ));
    vq.push_back(mk(8'd3,   8'd9,   1'b0, 8'd0, R_LT));
    vq.push_back(mk(8'h80,  8'h01,  1'b1, 8'd0, R_LT));
    vq.push_back(mk(8'hFF,  8'hFE,  1'b1, 8'd0, R_GT));
    vq.push_back(mk(8'h80,  8'h01,  1'b0, 8'd0, R_GT));
    vq.push_back(mk(8'hFF,  8'hFE,  1'b0, 8'd0, R_GT));
    vq.push_back(mk(8'h00,  8'hFF,  1'b1, 8'd0, R_GT));
    vq.push_back(mk(8'h00,  8'hFF,  1'b0, 8'd0, R_LT));
    vq.push_back(mk(8'h7F,  8'h80,  1'b1, 8'd0, R_GT));
    vq.push_back(mk(8'h81,  8'h81,  1'b1, 8'd0, R_EQ));
`ifdef CMP_STREAM_TOL_EN
    vq.push_back(mk(8'd10,  8'd12,  1'b0, 8'd2, R_EQ));
    vq.push_back(mk(8'd10,  8'd13,  1'b0, 8'd2, R_LT));
    vq.push_back(mk(8'hFF,  8'h01,  1'b1, 8'd2, R_EQ));
    vq.push_back(mk(8'hFF,  8'h01,  1'b0, 8'd2, R_GT));
    vq.push_back(mk(8'd14,  8'd10,  1'b0, 8'd3, R_GT));
`endif

    rst_n           = 1'b0;
    clr_cnt         = 1'b0;
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.signed_mode = 1'b0;
    bus.out_ready   = 1'b0;
`ifdef CMP_STREAM_TOL_EN
    bus.tol         = '0;
`endif
    #1;
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst a_gt", 32'(bus.a_gt), 32'd0);
    chk("rst b_gt", 32'(bus.b_gt), 32'd0);
    chk("rst eq", 32'(bus.eq), 32'd0);
    #21 rst_n = 1'b1;
    tick();
    chk("idle out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle in_ready", 32'(bus.in_ready), 32'd1);
    chk_cnt("idle");

    // Back-to-back vectors at full throughput.
    bus.out_ready = 1'b1;
    foreach (vq[i]) begin
      drive(vq[i].a, vq[i].b, vq[i].sm, vq[i].tol);
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'd1);
      tick();
      count(vq[i].res);
      chk_res($sformatf("v%0d", i), vq[i].res);
      chk_cnt($sformatf("v%0d", i));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("drain out_valid", 32'(bus.out_valid), 32'd0);
    chk_cnt("drain");

    // Back-pressure: hold a result, keep a new pair waiting, then hand off.
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    m_gt = 0; m_lt = 0; m_eq = 0;
    chk_cnt("clr");
    bus.out_ready = 1'b0;
    drive(8'd20, 8'd10, 1'b0, 8'd0);
    tick();
    count(R_GT);
    chk_res("bp first", R_GT);
    drive(8'd1, 8'd2, 1'b0, 8'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d in_ready", k), 32'(bus.in_ready), 32'd0);
      tick();
      chk_res($sformatf("bp%0d hold", k), R_GT);
      chk_cnt($sformatf("bp%0d", k));
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    count(R_LT);
    chk_res("bp handoff", R_LT);
    bus.in_valid = 1'b0;
    tick();
    chk("bp drain out_valid", 32'(bus.out_valid), 32'd0);
    chk_cnt("bp after");

    // Saturation of gt_cnt, then clear colliding with an accepted A<B pair.
    for (int k = 0; k < 5; k++) begin
      drive(8'(30 + k), 8'd7, 1'b0, 8'd0);
      tick();
      count(R_GT);
      chk_res($sformatf("sat%0d", k), R_GT);
      chk_cnt($sformatf("sat%0d", k));
    end
    chk("sat gt_cnt at max", 32'(gt_cnt), 32'(CMAX));
    clr_cnt = 1'b1;
    drive(8'd1, 8'd9, 1'b0, 8'd0);
    tick();
    m_gt = 0; m_lt = 0; m_eq = 0;
    chk_res("clr+acc", R_LT);
    chk_cnt("clr+acc");
    clr_cnt = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("clr after out_valid", 32'(bus.out_valid), 32'd0);
    chk_cnt("clr after");

    // Reset asserted while a result is pending.
    bus.out_ready = 1'b0;
    drive(8'd9, 8'd9, 1'b0, 8'd0);
    tick();
    count(R_EQ);
    chk_res("pre-reset", R_EQ);
    chk_cnt("pre-reset");
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    m_gt = 0; m_lt = 0; m_eq = 0;
    chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst in_ready", 32'(bus.in_ready), 32'd1);
    chk_cnt("midrst");
    #2 rst_n = 1'b1;
    tick();
    chk("post-reset out_valid", 32'(bus.out_valid), 32'd0);
    chk_cnt("post-reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmp_stream.md
Name: cmp_stream

Overview:
Parametrised, registered magnitude comparator with valid/ready handshake on input and output. Supports signed and unsigned operands and keeps saturating event counters for greater, less and equal results. Sits between a producer of operand pairs and a downstream consumer, replacing the fixed 4-bit combinational compare with a pipelined, back-pressure-aware stage.

Parameters:
WIDTH, 8, operand width in bits (>=2).
CNT_W, 16, width of each event counter (>=2).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand pair a/b/signed_mode is valid.
in_ready  output  1  stage can accept a pair this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with the pair.
out_valid  output  1  result registers hold an unconsumed result.
out_ready  input  1  consumer accepts the result this cycle.
a_gt  output  1  A > B for the held result.
b_gt  output  1  B > A for the held result.
eq  output  1  A == B for the held result.
clr_cnt  input  1  synchronous clear of all three counters.
gt_cnt  output  CNT_W  number of accepted pairs with A > B.
lt_cnt  output  CNT_W  number of accepted pairs with A < B.
eq_cnt  output  CNT_W  number of accepted pairs with A == B.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, a_gt=0, b_gt=0, eq=0, all counters=0. in_ready=1 once reset is released.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- On accept: compute the result from a, b and signed_mode, and register it into a_gt/b_gt/eq. Set out_valid=1. Latency is 1 cycle from accept to out_valid.
- Exactly one of a_gt/b_gt/eq is 1 whenever out_valid=1. Flags hold their value while out_valid=1 and out_ready=0.
- out_valid=1 with out_ready=1 and no new accept: out_valid goes to 0 next cycle. The flags keep their stale values and are don't-care.
- Consume and accept in the same cycle: the new result is loaded and out_valid stays 1 (full throughput, one pair per cycle).
- Signed mode: the MSB is the sign bit. Example: WIDTH=8, a=8'h80 (-128), b=8'h01 → b_gt. Unsigned mode with the same operands → a_gt.
- Counters: the matching counter increments by 1 on each accept. Counters saturate at 2^CNT_W-1 and never wrap.
- clr_cnt has priority: if clr_cnt and accept occur in the same cycle, all counters become 0 and that pair is not counted. The result path is unaffected.
- Counter outputs are registered and reflect accepts up to the previous edge.
- Reset asserted mid-stream: the pending result is discarded and the counters are cleared.

Optional Feature:
Macro CMP_STREAM_TOL_EN.
- Defined: adds input port tol [WIDTH-1:0], sampled with the pair. The result is eq=1 when |A-B| <= tol. The difference is computed in WIDTH+1 bits, respecting signed_mode. Otherwise a_gt/b_gt are set per the normal compare. eq_cnt counts tolerance matches.
- Undefined: no tol port; exact equality as above.

Test Plan:
- Reset release, no traffic → out_valid=0, in_ready=1, counters 0; assert rst_n low mid-result → out_valid drops immediately.
- WIDTH=8 unsigned: pairs (200,100), (5,5), (3,9) with out_ready=1 → results a_gt, eq, b_gt on consecutive cycles 1 cycle after accept; gt_cnt=1, eq_cnt=1, lt_cnt=1.
- signed_mode=1: (8'h80, 8'h01) → b_gt; (8'hFF, 8'hFE) → a_gt; same pairs with signed_mode=0 → a_gt, a_gt.
- Back-pressure: out_ready=0 for 3 cycles after one result → in_ready=0, flags stable; raise out_ready with a new pair valid → handoff with no bubble and no lost or duplicated pair.
- CNT_W=2: 5 pairs with A>B → gt_cnt saturates at 3; clr_cnt asserted with an accepted A<B pair → all counters 0 and lt_cnt stays 0.
- With CMP_STREAM_TOL_EN: tol=2, (10,12) → eq; (10,13) → b_gt; signed (-1,1) with tol=2 → eq.
